// File: rtl/rv32_pkg.sv
// Shared writeback types for the integer pipeline.
//   XLEN       : architectural data width
//   reg_idx_t  : 5-bit register file index
//   wb_entry_t : one pending register write {rd, data}
//   rd_onehot  : decodes a register index into a 32-bit hazard bit (x0 never hazards)
package rv32_pkg;

  localparam int XLEN = 32;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t            rd;
    logic [XLEN-1:0]     data;
  } wb_entry_t;

  // x0 is hardwired to zero, so it can never be the target of a pending write.
  function automatic logic [31:0] rd_onehot(input reg_idx_t idx);
    logic [31:0] v;
    v    = 32'd1 << idx;
    v[0] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer for ALU results that lost writeback arbitration.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_push       : enqueue i_push_entry at the tail (ignored when full)
//   i_pop        : dequeue the head (ignored when empty)
//   o_head       : current head entry
//   o_full       : count == DEPTH
//   o_empty      : count == 0
//   o_count      : number of stored entries, 0..DEPTH
//   o_valid      : per-slot occupancy, used for hazard mask generation
//   o_rd         : per-slot destination register
module wb_fifo
  import rv32_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  wb_entry_t                i_push_entry,
  input  logic                     i_pop,
  output wb_entry_t                o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [CW-1:0]            o_count,
  output logic [DEPTH-1:0]         o_valid,
  output reg_idx_t [DEPTH-1:0]     o_rd
);

  wb_entry_t           r_mem [DEPTH];
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic [DEPTH-1:0]    r_valid;
  logic                w_do_push;
  logic                w_do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_valid   = r_valid;
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Payload storage needs no reset: r_valid gates every use of it.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      // Clear before set so a push into the slot just freed stays valid.
      if (w_do_pop) begin
        r_rptr          <= ptr_next(r_rptr);
        r_valid[r_rptr] <= 1'b0;
      end
      if (w_do_push) begin
        r_wptr          <= ptr_next(r_wptr);
        r_valid[r_wptr] <= 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) o_rd[i] = r_mem[i].rd;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results onto the single register file
// write port, buffering ALU results that lose and publishing a hazard mask.
//   clk, rst_n               : clock, asynchronous active-low reset
//   alu_valid/ready/rd/data  : ALU result handshake
//   lsu_valid/ready/rd/data  : load result handshake
//   w_en, rd, w_data         : registered register file write
//   hazard_mask              : registers with a write still buffered or in flight
//   busy                     : buffer non-empty or a write in the output register
module wb_arbiter
  import rv32_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  reg_idx_t          alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  reg_idx_t          lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              w_en,
  output reg_idx_t          rd,
  output logic [XLEN-1:0]   w_data,
  output logic [31:0]       hazard_mask,
  output logic              busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic [DEPTH-1:0]      w_valid;
  reg_idx_t [DEPTH-1:0]  w_rd;
  wb_entry_t             w_head;
  wb_entry_t             w_alu_entry;
  wb_entry_t             w_sel;
  logic                  w_sel_valid;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_bypass;
  logic                  w_force;
  logic                  w_alu_live;
  logic                  w_lsu_live;
  logic [31:0]           w_mask;

  logic [SW-1:0]         r_starve;
  logic                  r_wen;
  reg_idx_t              r_rd;
  logic [XLEN-1:0]       r_wdata;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_entry (w_alu_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count),
    .o_valid      (w_valid),
    .o_rd         (w_rd)
  );

  assign w_force   = !w_empty && (r_starve == SW'(STARVE_LIMIT));
  assign alu_ready = !w_full;
  assign lsu_ready = !w_force;

  // rd == 0 results complete the handshake but are otherwise invisible.
  assign w_alu_live = alu_valid && alu_ready && (alu_rd != '0);
  assign w_lsu_live = lsu_valid && lsu_ready && (lsu_rd != '0);

  assign w_alu_entry.rd   = alu_rd;
  assign w_alu_entry.data = alu_data;

  always_comb begin
    w_pop       = 1'b0;
    w_bypass    = 1'b0;
    w_sel_valid = 1'b0;
    w_sel       = '0;
    if (w_force) begin
      w_pop       = 1'b1;
      w_sel_valid = 1'b1;
      w_sel       = w_head;
    end else if (w_lsu_live) begin
      w_sel_valid = 1'b1;
      w_sel.rd    = lsu_rd;
      w_sel.data  = lsu_data;
    end else if (!w_empty) begin
      w_pop       = 1'b1;
      w_sel_valid = 1'b1;
      w_sel       = w_head;
    end else if (w_alu_live) begin
      w_bypass    = 1'b1;
      w_sel_valid = 1'b1;
      w_sel       = w_alu_entry;
    end
  end

  assign w_push = w_alu_live && !w_bypass;

  // Counts cycles the head sits unpopped; reaching the limit forces a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_empty || w_pop) begin
      r_starve <= '0;
    end else if (r_starve != SW'(STARVE_LIMIT)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen   <= 1'b0;
      r_rd    <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= w_sel_valid;
      if (w_sel_valid) begin
        r_rd    <= w_sel.rd;
        r_wdata <= w_sel.data;
      end
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i]) w_mask = w_mask | rd_onehot(w_rd[i]);
    end
    if (r_wen) w_mask = w_mask | rd_onehot(r_rd);
  end

  assign w_en        = r_wen;
  assign rd          = r_rd;
  assign w_data      = r_wdata;
  assign hazard_mask = w_mask;
  assign busy        = (w_count != '0) || r_wen;

endmodule
